// File: rtl/mod10_pkg.sv
// Shared types and constants for the mod-10 sequence checker.
package mod10_pkg;

    typedef enum logic [1:0] {
        HUNT,
        ACQ,
        LOCKED
    } state_t;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [7:0] ERRCNT_MAX = 8'd255;

    // Decade successor: 9 wraps to 0, never yields 10..15.
    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd2_tally.sv
// Two-digit BCD incrementer (00..99, wraps to 00) with synchronous clear and enable.
module bcd2_tally (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] tally
);
    import mod10_pkg::*;

    logic [3:0] ones;
    logic [3:0] tens;

    assign ones = tally[3:0];
    assign tens = tally[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tally <= '0;
        end else if (clr) begin
            tally <= '0;
        end else if (en) begin
            if (ones == DIGIT_MAX) begin
                tally <= {digit_inc(tens), 4'd0};
            end else begin
                tally <= {tens, digit_inc(ones)};
            end
        end
    end

endmodule

// File: rtl/mod10_checker.sv
// Checks a sampled mod-10 up-count sequence: hunts for 0, acquires lock, flags errors.
// Optional error counter enabled by defining MOD10_CHK_ERRCNT_EN.
module mod10_checker #(
    parameter int unsigned LOCK_CNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q_in,
    input  logic       valid_in,
    output logic       locked,
    output logic       wrap_pulse,
    output logic       err_pulse,
    output logic       bad_code,
    output logic [7:0] tally,
    output logic [7:0] err_count
);
    import mod10_pkg::*;

    // A fresh 0 either starts acquisition or, with LOCK_CNT==1, locks outright.
    localparam state_t     RESTART_ST = (LOCK_CNT == 1) ? LOCKED : ACQ;
    localparam logic [4:0] LOCK_TGT   = 5'(LOCK_CNT);

    state_t     state;
    logic [3:0] exp;
    logic [3:0] run;
    logic [4:0] run_nxt;
    logic       match;
    logic       is_zero;
    logic       is_bad;
    logic       wrap_evt;

    assign match    = (q_in == exp);
    assign is_zero  = (q_in == 4'd0);
    assign is_bad   = (q_in > DIGIT_MAX);
    assign run_nxt  = {1'b0, run} + 5'd1;
    assign wrap_evt = valid_in && (state == LOCKED) && match && is_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            exp        <= '0;
            run        <= '0;
            locked     <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            bad_code   <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            bad_code   <= 1'b0;
            if (valid_in) begin
                bad_code <= is_bad;
                case (state)
                    HUNT: begin
                        if (is_zero) begin
                            state  <= RESTART_ST;
                            locked <= (RESTART_ST == LOCKED);
                            exp    <= 4'd1;
                            run    <= 4'd1;
                        end
                    end
                    ACQ: begin
                        if (match) begin
                            run <= run_nxt[3:0];
                            exp <= digit_inc(exp);
                            if (run_nxt >= LOCK_TGT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (is_zero) begin
                            state  <= RESTART_ST;
                            locked <= (RESTART_ST == LOCKED);
                            exp    <= 4'd1;
                            run    <= 4'd1;
                        end else begin
                            state <= HUNT;
                            exp   <= '0;
                            run   <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            exp        <= digit_inc(exp);
                            wrap_pulse <= is_zero;
                        end else begin
                            err_pulse <= 1'b1;
                            if (is_zero) begin
                                state  <= RESTART_ST;
                                locked <= (RESTART_ST == LOCKED);
                                exp    <= 4'd1;
                                run    <= 4'd1;
                            end else begin
                                state  <= HUNT;
                                locked <= 1'b0;
                                exp    <= '0;
                                run    <= '0;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        exp    <= '0;
                        run    <= '0;
                    end
                endcase
            end
        end
    end

    bcd2_tally u_tally (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (wrap_evt),
        .tally (tally)
    );

`ifdef MOD10_CHK_ERRCNT_EN
    logic err_evt;

    assign err_evt = valid_in && (state == LOCKED) && !match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_evt && (err_count != ERRCNT_MAX)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_mod10_checker.sv
// Scoreboard bench for mod10_checker: a behavioural model queues expected outputs per sample.
module tb_mod10_checker;

    localparam int unsigned L = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] q_in;
    logic       valid_in;
    logic       locked;
    logic       wrap_pulse;
    logic       err_pulse;
    logic       bad_code;
    logic [7:0] tally;
    logic [7:0] err_count;

    mod10_checker #(.LOCK_CNT(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .valid_in   (valid_in),
        .locked     (locked),
        .wrap_pulse (wrap_pulse),
        .err_pulse  (err_pulse),
        .bad_code   (bad_code),
        .tally      (tally),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       locked;
        logic       wrap;
        logic       err;
        logic       bad;
        logic [7:0] tally;
        logic [7:0] ec;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // model state: 0=hunt 1=acq 2=locked; tally kept as a plain 0..99 integer
    int m_st, m_exp, m_run, m_tally, m_err;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_reset();
        m_st = 0; m_exp = 0; m_run = 0; m_tally = 0; m_err = 0;
    endtask

    task automatic model_restart();
        m_st  = (L == 1) ? 2 : 1;
        m_exp = 1;
        m_run = 1;
    endtask

    task automatic model_step(input bit v, input int s, output exp_t e);
        e.wrap = 1'b0; e.err = 1'b0; e.bad = 1'b0;
        if (v) begin
            e.bad = (s > 9);
            if (m_st == 0) begin
                if (s == 0) model_restart();
            end else if (m_st == 1) begin
                if (s == m_exp) begin
                    m_run++;
                    m_exp = (m_exp + 1) % 10;
                    if (m_run >= L) m_st = 2;
                end else if (s == 0) begin
                    model_restart();
                end else begin
                    m_st = 0;
                end
            end else begin
                if (s == m_exp) begin
                    if (s == 0) begin
                        e.wrap  = 1'b1;
                        m_tally = (m_tally + 1) % 100;
                    end
                    m_exp = (m_exp + 1) % 10;
                end else begin
                    e.err = 1'b1;
                    if (m_err < 255) m_err++;
                    if (s == 0) model_restart();
                    else m_st = 0;
                end
            end
        end
        e.locked = (m_st == 2);
        e.tally  = to_bcd(m_tally);
`ifdef MOD10_CHK_ERRCNT_EN
        e.ec = 8'(m_err);
`else
        e.ec = 8'h00;
`endif
    endtask

    task automatic send(input bit v, input int s);
        exp_t e, g;
        @(negedge clk);
        valid_in = v;
        q_in     = 4'(s);
        model_step(v, s, e);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("queue_empty", 8'd0, 8'd1);
        end else begin
            g = q.pop_front();
            check("locked", {7'd0, locked},     {7'd0, g.locked});
            check("wrap",   {7'd0, wrap_pulse}, {7'd0, g.wrap});
            check("err",    {7'd0, err_pulse},  {7'd0, g.err});
            check("bad",    {7'd0, bad_code},   {7'd0, g.bad});
            check("tally",  tally,              g.tally);
            check("errcnt", err_count,          g.ec);
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; q_in = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_locked", {7'd0, locked},     8'd0);
        check("rst_wrap",   {7'd0, wrap_pulse}, 8'd0);
        check("rst_err",    {7'd0, err_pulse},  8'd0);
        check("rst_bad",    {7'd0, bad_code},   8'd0);
        check("rst_tally",  tally,              8'h00);
        check("rst_errcnt", err_count,          8'h00);
        rst = 1'b0;

        // 0..9,0: lock after sample 1, wrap on second 0
        send(1, 0);
        check("not_locked_after_0", {7'd0, locked}, 8'd0);
        send(1, 1);
        check("locked_after_1", {7'd0, locked}, 8'd1);
        for (int i = 2; i <= 9; i++) send(1, i);
        send(1, 0);
        check("tally_one_wrap", tally, 8'h01);

        // gap between 4 and 5 keeps lock, no pulses
        for (int i = 1; i <= 4; i++) send(1, i);
        for (int i = 0; i < 5; i++) send(0, 4'hA);
        send(1, 5);
        check("locked_after_gap", {7'd0, locked}, 8'd1);

        // sequence error 3,5 after fresh lock
        send(1, 0); send(1, 1); send(1, 2); send(1, 3); send(1, 5);
        check("locked_dropped", {7'd0, locked}, 8'd0);

        // bad code while locked
        send(1, 0); send(1, 1); send(1, 2); send(1, 12);

        // async reset while locked at exp=6
        for (int i = 0; i <= 5; i++) send(1, i);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_locked", {7'd0, locked}, 8'd0);
        check("async_rst_tally",  tally,          8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send(1, 6); send(1, 7);
        check("hunt_after_rst", {7'd0, locked}, 8'd0);

        // 100 full decades: tally wraps back to 00
        send(1, 0); send(1, 1);
        for (int i = 0; i < 1000; i++) send(1, (i + 2) % 10);
        check("tally_wrap_99_00", tally, 8'h00);

        // 256 forced errors: a 0 at exp=2 errs into ACQ, the following 1 re-locks
        for (int i = 0; i < 256; i++) begin
            send(1, 0);
            send(1, 1);
        end
`ifdef MOD10_CHK_ERRCNT_EN
        check("errcnt_saturated", err_count, 8'd255);
`else
        check("errcnt_absent", err_count, 8'd0);
`endif

        // mixed traffic: mostly in-sequence with random gaps and corruptions
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8) send($urandom_range(0, 4) != 0, m_exp);
            else send(1, int'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
